// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: channel indices and
// the occupancy-counter width helper.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO: a push is visible at the head one cycle later;
// push is dropped when full and pop is ignored when empty (caller gates on full/empty).
module chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [level_w(DEPTH)-1:0] level_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  // Pointers are exactly log2(DEPTH) bits, so wrap-around is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/demux12_stream.sv
// Streaming 1-to-2 demux routing by select bit or alternating pointer into two FIFOs.
// Latency 1 cycle; in_ready drops while the current target channel is full (no pass-through).
module demux12_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sel,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      alt_mode,
  input  logic                      sync,
  output logic                      y0_valid,
  input  logic                      y0_ready,
  output logic [WIDTH-1:0]          y0_data,
  output logic [level_w(DEPTH)-1:0] y0_level,
  output logic                      y1_valid,
  input  logic                      y1_ready,
  output logic [WIDTH-1:0]          y1_data,
  output logic [level_w(DEPTH)-1:0] y1_level
);

  logic tog_q, tog_d;
  logic tgt, accept;
  logic full0, full1, empty0, empty1;

  assign tgt      = alt_mode ? tog_q : in_sel;
  assign in_ready = (tgt == CH1) ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;
  assign y0_valid = ~empty0;
  assign y1_valid = ~empty1;

  // sync wins over the flip; the word accepted this cycle was already routed by the old tog.
  always_comb begin
    tog_d = tog_q;
    if (sync) tog_d = 1'b0;
    else if (accept && alt_mode) tog_d = ~tog_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= tog_d;
  end

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept && (tgt == CH0)),
    .push_data_i(in_data),
    .pop_i      (y0_valid & y0_ready),
    .data_o     (y0_data),
    .level_o    (y0_level),
    .full_o     (full0),
    .empty_o    (empty0)
  );

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept && (tgt == CH1)),
    .push_data_i(in_data),
    .pop_i      (y1_valid & y1_ready),
    .data_o     (y1_data),
    .level_o    (y1_level),
    .full_o     (full1),
    .empty_o    (empty1)
  );

endmodule

// File: tb/tb_demux12_stream.sv
// Directed bench for demux12_stream (WIDTH=4, DEPTH=2): vector table plus reset sequence.
module tb_demux12_stream;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_sel, alt_mode, sync;
  logic [WIDTH-1:0] in_data;
  logic             y0_valid, y0_ready, y1_valid, y1_ready;
  logic [WIDTH-1:0] y0_data, y1_data;
  logic [1:0]       y0_level, y1_level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux12_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .alt_mode(alt_mode), .sync(sync),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_level(y0_level),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_level(y1_level)
  );

  typedef struct {
    logic       v, sel;
    logic [3:0] d;
    logic       alt, syn, r0, r1;
    logic       e_rdy, e_v0;
    logic [3:0] e_d0;
    logic [1:0] e_l0;
    logic       e_v1;
    logic [3:0] e_d1;
    logic [1:0] e_l1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic sel, logic [3:0] d, logic alt, logic syn,
                              logic r0, logic r1, logic e_rdy, logic e_v0, logic [3:0] e_d0,
                              logic [1:0] e_l0, logic e_v1, logic [3:0] e_d1, logic [1:0] e_l1);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.alt = alt; t.syn = syn; t.r0 = r0; t.r1 = r1;
    t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_l0 = e_l0;
    t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_l1 = e_l1;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [3:0] d, input logic alt,
                       input logic syn, input logic r0, input logic r1);
    in_valid = v; in_sel = sel; in_data = d; alt_mode = alt; sync = syn;
    y0_ready = r0; y1_ready = r1;
  endtask

  initial begin
    // Observed values are the state before the rising edge that applies the row's inputs.
    //               v sel  d   alt syn r0 r1 | rdy v0  d0  l0 v1  d1  l1
    // explicit routing
    tbl.push_back(mk(1, 0, 4'hA, 0, 0, 1, 1,   1, 0, 4'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 1, 4'h5, 0, 0, 1, 1,   1, 1, 4'hA, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h3, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h5, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1,   1, 1, 4'h3, 1, 0, 4'h0, 0));
    // backpressure on Y0, full with same-cycle pop, in_ready tracks target
    tbl.push_back(mk(1, 0, 4'h1, 0, 0, 0, 1,   1, 0, 4'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h2, 0, 0, 0, 1,   1, 1, 4'h1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h3, 0, 0, 0, 1,   0, 1, 4'h1, 2, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h3, 0, 0, 1, 1,   0, 1, 4'h1, 2, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h3, 0, 0, 0, 1,   1, 1, 4'h2, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1,   1, 1, 4'h2, 2, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1,   0, 1, 4'h2, 2, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1,   1, 1, 4'h3, 1, 0, 4'h0, 0));
    // alternating mode, sync with tog=1 then with tog=0
    tbl.push_back(mk(1, 0, 4'h1, 1, 0, 1, 1,   1, 0, 4'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h2, 1, 0, 1, 1,   1, 1, 4'h1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h3, 1, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h2, 1));
    tbl.push_back(mk(1, 0, 4'h4, 1, 0, 1, 1,   1, 1, 4'h3, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h5, 1, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h4, 1));
    tbl.push_back(mk(1, 0, 4'h6, 1, 1, 1, 1,   1, 1, 4'h5, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h7, 1, 1, 1, 1,   1, 0, 4'h0, 0, 1, 4'h6, 1));
    tbl.push_back(mk(1, 0, 4'h8, 1, 0, 1, 1,   1, 1, 4'h7, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 1,   1, 1, 4'h8, 1, 0, 4'h0, 0));
    // tog holds across an alt_mode=0 stretch
    tbl.push_back(mk(1, 0, 4'h9, 0, 0, 1, 1,   1, 0, 4'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'hC, 1, 0, 1, 1,   1, 1, 4'h9, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'hC, 1));
    // simultaneous push/pop on Y1 at level 1
    tbl.push_back(mk(1, 1, 4'h1, 0, 0, 1, 0,   1, 0, 4'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 1, 4'h2, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h1, 1));
    tbl.push_back(mk(1, 1, 4'h3, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h2, 1));
    tbl.push_back(mk(1, 1, 4'h4, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h3, 1));
    tbl.push_back(mk(1, 1, 4'h5, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h4, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 1, 1,   1, 0, 4'h0, 0, 1, 4'h5, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 1, 1,   1, 0, 4'h0, 0, 0, 4'h0, 0));

    rst_n = 1'b0;
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    #12;
    chk("rst_in_ready", -1, int'(in_ready), 1);
    chk("rst_y0_valid", -1, int'(y0_valid), 0);
    chk("rst_y1_valid", -1, int'(y1_valid), 0);
    chk("rst_y0_data",  -1, int'(y0_data), 0);
    chk("rst_y1_data",  -1, int'(y1_data), 0);
    chk("rst_y0_level", -1, int'(y0_level), 0);
    chk("rst_y1_level", -1, int'(y1_level), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].alt, tbl[i].syn, tbl[i].r0, tbl[i].r1);
      #1;
      chk("in_ready", i, int'(in_ready), int'(tbl[i].e_rdy));
      chk("y0_valid", i, int'(y0_valid), int'(tbl[i].e_v0));
      chk("y1_valid", i, int'(y1_valid), int'(tbl[i].e_v1));
      chk("y0_level", i, int'(y0_level), int'(tbl[i].e_l0));
      chk("y1_level", i, int'(y1_level), int'(tbl[i].e_l1));
      if (tbl[i].e_v0) chk("y0_data", i, int'(y0_data), int'(tbl[i].e_d0));
      if (tbl[i].e_v1) chk("y1_data", i, int'(y1_data), int'(tbl[i].e_d1));
    end

    // Reset mid-stream: alt mode leaves Y0=2, Y1=1 and tog=1 before reset hits.
    @(negedge clk); drive(1, 0, 4'h1, 1, 0, 0, 0);
    @(negedge clk); drive(1, 0, 4'h2, 1, 0, 0, 0);
    @(negedge clk); drive(1, 0, 4'h3, 1, 0, 0, 0);
    @(negedge clk); drive(0, 0, 4'h0, 1, 0, 0, 0);
    #1;
    chk("pre_rst_y0_level", 100, int'(y0_level), 2);
    chk("pre_rst_y1_level", 100, int'(y1_level), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y0_valid", 101, int'(y0_valid), 0);
    chk("mid_rst_y1_valid", 101, int'(y1_valid), 0);
    chk("mid_rst_y0_level", 101, int'(y0_level), 0);
    chk("mid_rst_y1_level", 101, int'(y1_level), 0);
    chk("mid_rst_y0_data",  101, int'(y0_data), 0);
    chk("mid_rst_in_ready", 101, int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 4'hE, 1, 0, 0, 0);
    #1;
    chk("post_rst_in_ready", 102, int'(in_ready), 1);
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    #1;
    chk("post_rst_tog_y0_valid", 103, int'(y0_valid), 1);
    chk("post_rst_tog_y0_data",  103, int'(y0_data), 14);
    chk("post_rst_tog_y1_valid", 103, int'(y1_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
